// File: rtl/noc_ctrl_pkg.sv
// Shared definitions for the multicast tag scheduler: FSM states, node tag
// encodings and small elaboration-time helpers.
package noc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENC,
        ST_OUT,
        ST_DROP
    } sched_state_t;

    localparam logic [1:0] TAG_NONE  = 2'b00;
    localparam logic [1:0] TAG_LEFT  = 2'b01;
    localparam logic [1:0] TAG_RIGHT = 2'b10;
    localparam logic [1:0] TAG_BOTH  = 2'b11;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Heap node j (1..N-1) owns the two tag bits starting here in the tag bus.
    function automatic int node_offset(input int node);
        return 2 * (node - 1);
    endfunction

endpackage

// File: rtl/mc_tree_level_encoder.sv
// One level of the binary multicast tree: turns the children's "any" bits
// into the parents' "any" bits and their 2-bit routing tags.
module mc_tree_level_encoder
    import noc_ctrl_pkg::*;
#(
    parameter int LEVEL = 0
) (
    input  logic [(2 << LEVEL)-1:0] child_any,
    output logic [(1 << LEVEL)-1:0] parent_any,
    output logic [(2 << LEVEL)-1:0] parent_tag
);

    always_comb begin
        parent_any = '0;
        parent_tag = '0;
        for (int i = 0; i < (1 << LEVEL); i++) begin
            parent_tag[2*i +: 2] = (child_any[2*i]   ? TAG_LEFT  : TAG_NONE) |
                                   (child_any[2*i+1] ? TAG_RIGHT : TAG_NONE);
            parent_any[i]        = |parent_tag[2*i +: 2];
        end
    end

endmodule

// File: rtl/multicast_tag_scheduler.sv
// Accepts a payload plus destination mask, builds the binary-tree routing tags
// one level per cycle (leaves to root), then offers the tagged packet downstream.
module multicast_tag_scheduler
    import noc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int NUM_OUTPUT_DATA       = 8,
    parameter int DESTINATION_TAG_WIDTH = 2,
    parameter int DROP_CNT_WIDTH        = 16
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 i_en,
    input  logic                                                 i_valid,
    output logic                                                 i_ready,
    input  logic [DATA_WIDTH-1:0]                                i_data_bus,
    input  logic [NUM_OUTPUT_DATA-1:0]                           i_dst_mask,
    output logic                                                 o_valid,
    input  logic                                                 o_ready,
    output logic [DATA_WIDTH-1:0]                                o_data_bus,
    output logic [DESTINATION_TAG_WIDTH*(NUM_OUTPUT_DATA-1)-1:0] o_tag_bus,
    output logic [DROP_CNT_WIDTH-1:0]                            o_drop_cnt
);

    localparam int LOG2N         = clog2(NUM_OUTPUT_DATA);
    localparam int TAG_BUS_WIDTH = DESTINATION_TAG_WIDTH * (NUM_OUTPUT_DATA - 1);
    localparam int LVL_W         = (LOG2N > 1) ? clog2(LOG2N) : 1;

    sched_state_t state, next_state;

    logic [LVL_W-1:0]           level;
    logic [NUM_OUTPUT_DATA-1:0] mask_reg;
    logic [NUM_OUTPUT_DATA-1:1] node_any;
    logic [NUM_OUTPUT_DATA-1:1] enc_any;
    logic [NUM_OUTPUT_DATA-1:1] level_sel;
    logic [TAG_BUS_WIDTH-1:0]   enc_tag;
    logic [TAG_BUS_WIDTH-1:0]   tag_sel;

    // Every level has its own encoder; only the one selected by level is committed.
    for (genvar lv = 0; lv < LOG2N; lv++) begin : g_level
        localparam int W = 1 << lv;
        logic [2*W-1:0] child_any;
        if (lv == LOG2N - 1) begin : g_leaf
            assign child_any = mask_reg;
        end else begin : g_inner
            assign child_any = node_any[2*W +: 2*W];
        end
        mc_tree_level_encoder #(
            .LEVEL(lv)
        ) u_enc (
            .child_any (child_any),
            .parent_any(enc_any[W +: W]),
            .parent_tag(enc_tag[node_offset(W) +: 2*W])
        );
    end

    always_comb begin
        level_sel = '0;
        tag_sel   = '0;
        for (int j = 1; j < NUM_OUTPUT_DATA; j++) begin
            level_sel[j]                 = (j >= (1 << level)) && (j < (2 << level));
            tag_sel[node_offset(j) +: 2] = {2{level_sel[j]}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (i_en) begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        i_ready    = 1'b0;
        if (i_en && rst_n) begin
            case (state)
                ST_IDLE: begin
                    i_ready = 1'b1;
                    if (i_valid) begin
                        next_state = (i_dst_mask == '0) ? ST_DROP : ST_ENC;
                    end
                end
                ST_ENC:  if (level == '0) next_state = ST_OUT;
                ST_OUT:  if (o_ready) next_state = ST_IDLE;
                ST_DROP: next_state = ST_IDLE;
                default: next_state = ST_IDLE;
            endcase
        end
        // Root "any" is always set for a real packet, so an empty tag set is never announced.
        o_valid = (state == ST_OUT) && node_any[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level      <= '0;
            mask_reg   <= '0;
            node_any   <= '0;
            o_data_bus <= '0;
            o_tag_bus  <= '0;
            o_drop_cnt <= '0;
        end else if (i_en) begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        o_data_bus <= i_data_bus;
                        mask_reg   <= i_dst_mask;
                        level      <= LVL_W'(LOG2N - 1);
                    end
                end
                ST_ENC: begin
                    node_any  <= (node_any & ~level_sel) | (enc_any & level_sel);
                    o_tag_bus <= (o_tag_bus & ~tag_sel) | (enc_tag & tag_sel);
                    level     <= level - 1'b1;
                end
                ST_DROP: begin
                    if (o_drop_cnt != '1) begin
                        o_drop_cnt <= o_drop_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicast_tag_scheduler.sv
// Randomised and directed bench for multicast_tag_scheduler, checked against a
// leaf-walking reference model of the tree tags.
module tb_multicast_tag_scheduler;

    localparam int DW    = 32;
    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int DCW   = 4;
    localparam int TBW   = 2 * (N - 1);

    logic           clk;
    logic           rst_n;
    logic           i_en;
    logic           i_valid;
    logic           i_ready;
    logic [DW-1:0]  i_data_bus;
    logic [N-1:0]   i_dst_mask;
    logic           o_valid;
    logic           o_ready;
    logic [DW-1:0]  o_data_bus;
    logic [TBW-1:0] o_tag_bus;
    logic [DCW-1:0] o_drop_cnt;

    int vectors;
    int miscompares;
    int drop_model;

    multicast_tag_scheduler #(
        .DATA_WIDTH           (DW),
        .NUM_OUTPUT_DATA      (N),
        .DESTINATION_TAG_WIDTH(2),
        .DROP_CNT_WIDTH       (DCW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (i_en),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_data_bus(i_data_bus),
        .i_dst_mask(i_dst_mask),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data_bus(o_data_bus),
        .o_tag_bus (o_tag_bus),
        .o_drop_cnt(o_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A node sees a destination if walking that leaf up the heap reaches it.
    function automatic bit anyBelow(input logic [N-1:0] mask, input int node);
        for (int k = 0; k < N; k++) begin
            int n;
            n = N + k;
            while (n > node) n = n >> 1;
            if (n == node && mask[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [TBW-1:0] expTags(input logic [N-1:0] mask);
        logic [TBW-1:0] t;
        t = '0;
        for (int j = 1; j < N; j++) begin
            t[2*(j-1) +: 2] = {anyBelow(mask, 2*j+1), anyBelow(mask, 2*j)};
        end
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge with the scheduler idle; returns at a negedge.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic [N-1:0] mask,
                                 input logic [TBW-1:0] exp_tags, input int hold, input int gap);
        int lat;
        checkOutput("idle_ready", i_ready, 1);
        i_valid    = 1'b1;
        i_data_bus = data;
        i_dst_mask = mask;
        @(negedge clk);
        i_valid    = 1'b0;
        i_data_bus = $urandom;
        i_dst_mask = N'($urandom);
        if (mask == '0) begin
            if (drop_model < (1 << DCW) - 1) drop_model++;
            checkOutput("drop_busy", {o_valid, i_ready}, 2'b00);
            @(negedge clk);
            checkOutput("drop_cnt", o_drop_cnt, drop_model);
            checkOutput("drop_no_valid", o_valid, 0);
            return;
        end
        lat = 1;
        while (!o_valid && lat < 40) begin
            if (gap > 0 && lat == 2) begin
                i_en = 1'b0;
                repeat (gap) begin
                    @(negedge clk);
                    lat++;
                    checkOutput("en_freeze", {o_valid, i_ready}, 2'b00);
                end
                i_en = 1'b1;
            end
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, LOG2N + 1 + gap);
        checkOutput("data", o_data_bus, data);
        checkOutput("tags", o_tag_bus, exp_tags);
        o_ready = 1'b0;
        repeat (hold) @(negedge clk);
        checkOutput("hold_flags", {o_valid, i_ready}, 2'b10);
        checkOutput("hold_data", o_data_bus, data);
        checkOutput("hold_tags", o_tag_bus, exp_tags);
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        checkOutput("release", {o_valid, i_ready}, 2'b01);
        checkOutput("tags_kept", o_tag_bus, exp_tags);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        drop_model  = 0;
        rst_n       = 1'b0;
        i_en        = 1'b1;
        i_valid     = 1'b0;
        i_data_bus  = '0;
        i_dst_mask  = '0;
        o_ready     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_flags", {o_valid, i_ready}, 2'b00);
        checkOutput("rst_data", o_data_bus, 0);
        checkOutput("rst_tags", o_tag_bus, 0);
        checkOutput("rst_drop", o_drop_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(32'hA5A5_0001, 8'b0000_0001, 14'h0045, 0, 0);
        applyStimulus(32'h1234_5678, 8'b1000_0001, 14'h2067, 1, 0);
        applyStimulus(32'hFFFF_0000, 8'hFF, 14'h3FFF, 0, 0);
        applyStimulus(32'hDEAD_BEEF, 8'h00, '0, 0, 0);
        applyStimulus(32'h0BAD_CAFE, 8'b0100_1000, expTags(8'b0100_1000), 5, 0);
        applyStimulus(32'h0000_0003, 8'b1000_0001, 14'h2067, 0, 3);

        // Reset in the middle of tag encoding discards the packet.
        i_valid    = 1'b1;
        i_data_bus = 32'h5555_AAAA;
        i_dst_mask = 8'hF0;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        drop_model = 0;
        checkOutput("midrst_flags", {o_valid, i_ready}, 2'b00);
        checkOutput("midrst_tags", o_tag_bus, 0);
        checkOutput("midrst_drop", o_drop_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", i_ready, 1);

        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] d;
            logic [N-1:0]  m;
            d = $urandom;
            m = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            applyStimulus(d, m, expTags(m), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        for (int n = 0; n < 18; n++) begin
            applyStimulus($urandom, '0, '0, 0, 0);
        end
        checkOutput("drop_saturated", o_drop_cnt, (1 << DCW) - 1);
        applyStimulus(32'hCAFE_F00D, 8'b0010_0100, expTags(8'b0010_0100), 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
